// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command controller: ASCII command codes
// and the controller FSM state encoding.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_R = 8'h72;
    localparam logic [7:0] CMD_L = 8'h6C;
    localparam logic [7:0] CMD_U = 8'h75;
    localparam logic [7:0] CMD_D = 8'h64;
    localparam logic [7:0] CMD_S = 8'h73;
    localparam logic [7:0] SW0   = 8'h30;
    localparam logic [7:0] SW1   = 8'h31;
    localparam logic [7:0] SW2   = 8'h32;
    localparam logic [7:0] NAK   = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_TX_REQ,
        ST_TX_HOLD,
        ST_TX_WAIT
    } state_t;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous byte FIFO buffering received UART bytes.
// Ports: clk, rst (sync, active-high), push/din in, pop/dout out, full, empty.
module uart_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: buffers rx bytes, decodes one command at a time,
// pulses buttons, toggles switch levels and sends one TX reply at a time.
// Ports: clk, rst; rx_data/rx_done in; tx_busy in; tx_start/tx_data out;
// uart_btn_r/l/u/d pulses; uart_sw_* levels; rx_ovf sticky overflow flag.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit ECHO_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       uart_btn_r,
    output logic       uart_btn_l,
    output logic       uart_btn_u,
    output logic       uart_btn_d,
    output logic       uart_sw_mode,
    output logic       uart_sw_sel_mode,
    output logic       uart_sw_sel_display,
    output logic       rx_ovf
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cmd_reg;
    logic [7:0] reply;
    logic [7:0] reply_nxt;
    logic [3:0] btn;
    logic [3:0] btn_nxt;
    logic [2:0] sw;
    logic [2:0] sw_flip;
    logic       start_nxt;
    logic       owed;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;

    uart_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (rx_done),
        .pop  (fifo_pop),
        .din  (rx_data),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign uart_btn_r          = btn[0];
    assign uart_btn_l          = btn[1];
    assign uart_btn_u          = btn[2];
    assign uart_btn_d          = btn[3];
    assign uart_sw_mode        = sw[0];
    assign uart_sw_sel_mode    = sw[1];
    assign uart_sw_sel_display = sw[2];

    always_comb begin
        state_nxt = state;
        reply_nxt = reply;
        btn_nxt   = '0;
        sw_flip   = '0;
        start_nxt = 1'b0;
        owed      = 1'b0;
        fifo_pop  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                owed      = ECHO_EN;
                reply_nxt = cmd_reg;
                unique case (cmd_reg)
                    CMD_R: btn_nxt = 4'b0001;
                    CMD_L: btn_nxt = 4'b0010;
                    CMD_U: btn_nxt = 4'b0100;
                    CMD_D: btn_nxt = 4'b1000;
                    SW0:   sw_flip = 3'b001;
                    SW1:   sw_flip = 3'b010;
                    SW2:   sw_flip = 3'b100;
                    CMD_S: begin
                        // Status reflects levels before this cycle's update.
                        reply_nxt = SW0 | {5'b0, sw};
                        owed      = 1'b1;
                    end
                    default: reply_nxt = NAK;
                endcase
                state_nxt = owed ? ST_TX_REQ : ST_IDLE;
            end
            ST_TX_REQ: begin
                if (!tx_busy) begin
                    start_nxt = 1'b1;
                    state_nxt = ST_TX_HOLD;
                end
            end
            // tx_busy only rises after tx_start, so skip one cycle first.
            ST_TX_HOLD: state_nxt = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (!tx_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cmd_reg  <= '0;
            reply    <= '0;
            btn      <= '0;
            sw       <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            rx_ovf   <= 1'b0;
        end else begin
            state    <= state_nxt;
            reply    <= reply_nxt;
            btn      <= btn_nxt;
            sw       <= sw ^ sw_flip;
            tx_start <= start_nxt;
            if (fifo_pop) begin
                cmd_reg <= fifo_dout;
            end
            if (start_nxt) begin
                tx_data <= reply;
            end
            if (rx_done && fifo_full && !fifo_pop) begin
                rx_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: one echoing and one silent instance
// driven by the same rx stream, checked against an ordered command model.
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy [2];
    logic       tx_start [2];
    logic [7:0] tx_data [2];
    logic       btn_r [2];
    logic       btn_l [2];
    logic       btn_u [2];
    logic       btn_d [2];
    logic       sw_m [2];
    logic       sw_sm [2];
    logic       sw_sd [2];
    logic       ovf [2];

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.FIFO_DEPTH(4), .ECHO_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
        .uart_btn_r(btn_r[0]), .uart_btn_l(btn_l[0]),
        .uart_btn_u(btn_u[0]), .uart_btn_d(btn_d[0]),
        .uart_sw_mode(sw_m[0]), .uart_sw_sel_mode(sw_sm[0]),
        .uart_sw_sel_display(sw_sd[0]), .rx_ovf(ovf[0])
    );

    uart_cmd_ctrl #(.FIFO_DEPTH(4), .ECHO_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
        .uart_btn_r(btn_r[1]), .uart_btn_l(btn_l[1]),
        .uart_btn_u(btn_u[1]), .uart_btn_d(btn_d[1]),
        .uart_sw_mode(sw_m[1]), .uart_sw_sel_mode(sw_sm[1]),
        .uart_sw_sel_display(sw_sd[1]), .rx_ovf(ovf[1])
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int send_cyc = 0;

    logic [3:0] btn_list [$];
    logic [2:0] sw_list [$];
    logic [7:0] tx_list1 [$];
    logic [7:0] tx_list0 [$];
    int         bi [2];
    int         si [2];
    int         ti [2];
    int         cnt [2];
    logic       pend [2];
    int         btn_cyc [2];
    logic [3:0] prev_btn [2];
    logic [2:0] prev_sw [2];
    logic       prev_start [2];
    logic [7:0] prev_data [2];
    logic       hold;
    logic [2:0] m_sw;

    logic [7:0] pool [10] = '{8'h72, 8'h6C, 8'h75, 8'h64, 8'h30,
                              8'h31, 8'h32, 8'h73, 8'h58, 8'h00};

    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // Reference: commands take effect strictly in arrival order.
    task automatic model(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        case (b)
            8'h72: btn_list.push_back(4'b0001);
            8'h6C: btn_list.push_back(4'b0010);
            8'h75: btn_list.push_back(4'b0100);
            8'h64: btn_list.push_back(4'b1000);
            8'h30: begin m_sw[0] = ~m_sw[0]; sw_list.push_back(m_sw); end
            8'h31: begin m_sw[1] = ~m_sw[1]; sw_list.push_back(m_sw); end
            8'h32: begin m_sw[2] = ~m_sw[2]; sw_list.push_back(m_sw); end
            8'h73: begin r = 8'h30 + m_sw; tx_list0.push_back(r); end
            default: r = 8'h3F;
        endcase
        tx_list1.push_back(r);
    endtask

    function automatic bit all_done();
        bit d;
        d = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (bi[k] != btn_list.size() || si[k] != sw_list.size()) d = 1'b0;
            if (cnt[k] != 0 || pend[k]) d = 1'b0;
        end
        if (ti[1] != tx_list1.size() || ti[0] != tx_list0.size()) d = 1'b0;
        return d;
    endfunction

    task automatic tick();
        logic [3:0] b;
        logic [2:0] s;
        logic [7:0] e;
        int         n;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            b = {btn_d[k], btn_u[k], btn_l[k], btn_r[k]};
            s = {sw_sd[k], sw_sm[k], sw_m[k]};
            if (b != 4'b0) begin
                check("btn_width", int'(b & prev_btn[k]), 0);
                if (bi[k] < btn_list.size()) begin
                    check("btn", b, btn_list[bi[k]]);
                    bi[k]++;
                end else check("btn_extra", b, 0);
                btn_cyc[k] = cyc;
            end
            prev_btn[k] = b;
            if (s != prev_sw[k]) begin
                if (si[k] < sw_list.size()) begin
                    check("sw", s, sw_list[si[k]]);
                    si[k]++;
                end else check("sw_extra", s, prev_sw[k]);
            end
            prev_sw[k] = s;
            if (tx_start[k]) begin
                check("tx_one_cycle", prev_start[k], 0);
                check("tx_while_busy", tx_busy[k], 0);
                n = (k == 1) ? tx_list1.size() : tx_list0.size();
                if (ti[k] < n) begin
                    e = (k == 1) ? tx_list1[ti[k]] : tx_list0[ti[k]];
                    check("tx_data", tx_data[k], e);
                    ti[k]++;
                end else check("tx_extra", 1, 0);
            end else if (tx_data[k] != prev_data[k]) begin
                check("tx_data_hold", tx_data[k], prev_data[k]);
            end
            prev_start[k] = tx_start[k];
            prev_data[k]  = tx_data[k];
            // uart_tx model: busy starts the cycle after tx_start.
            if (cnt[k] > 0) cnt[k]--;
            if (pend[k]) begin
                cnt[k]  = $urandom_range(1, 8);
                pend[k] = 1'b0;
            end
            if (tx_start[k]) pend[k] = 1'b1;
            tx_busy[k] = hold || (cnt[k] > 0);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit upd);
        rx_data  = b;
        rx_done  = 1'b1;
        send_cyc = cyc;
        if (upd) model(b);
        tick();
        rx_done = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        rx_done = 1'b0;
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 2; k++) begin
            check("rst_btn", {btn_d[k], btn_u[k], btn_l[k], btn_r[k]}, 0);
            check("rst_sw", {sw_sd[k], sw_sm[k], sw_m[k]}, 0);
            check("rst_tx_start", tx_start[k], 0);
            check("rst_tx_data", tx_data[k], 0);
            check("rst_ovf", ovf[k], 0);
            bi[k] = 0; si[k] = 0; ti[k] = 0;
            cnt[k] = 0; pend[k] = 1'b0;
            prev_btn[k] = '0; prev_sw[k] = '0;
            prev_start[k] = 1'b0; prev_data[k] = '0;
            tx_busy[k] = hold;
        end
        btn_list.delete();
        sw_list.delete();
        tx_list1.delete();
        tx_list0.delete();
        m_sw = '0;
        rst  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!all_done() && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, all_done(), 1);
        repeat (8) tick();
        check({tag, "_sw1"}, {sw_sd[1], sw_sm[1], sw_m[1]}, m_sw);
        check({tag, "_sw0"}, {sw_sd[0], sw_sm[0], sw_m[0]}, m_sw);
    endtask

    initial begin
        int         n;
        int         len;
        int         idx;
        logic [7:0] b;
        rst = 1'b1;
        rx_done = 1'b0;
        rx_data = '0;
        hold = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tx_busy[k] = 1'b0;
            btn_cyc[k] = 0;
        end

        do_reset(2);
        send(8'h72, 1'b1);
        n = send_cyc;
        drain("t1");
        check("t1_lat1", btn_cyc[1] - n, 3);
        check("t1_lat0", btn_cyc[0] - n, 3);
        check("t1_echo", tx_data[1], 8'h72);

        send(8'h30, 1'b1);
        repeat (11) tick();
        send(8'h30, 1'b1);
        repeat (11) tick();
        send(8'h31, 1'b1);
        drain("t2");
        check("t2_mode", sw_m[0], 0);
        check("t2_sel_mode", sw_sm[0], 1);

        send(8'h58, 1'b1);
        drain("t3");
        check("t3_nak", tx_data[1], 8'h3F);

        send(8'h30, 1'b1);
        send(8'h32, 1'b1);
        send(8'h31, 1'b1);
        send(8'h73, 1'b1);
        drain("t4");
        check("t4_status1", tx_data[1], 8'h35);
        check("t4_status0", tx_data[0], 8'h35);

        hold = 1'b1;
        for (int i = 0; i < 5; i++) send(pool[$urandom_range(0, 6)], 1'b1);
        send(8'h5A, 1'b0);
        repeat (194) tick();
        check("t5_ovf1", ovf[1], 1);
        check("t5_ovf0", ovf[0], 0);
        hold = 1'b0;
        drain("t5");
        check("t5_ovf_sticky", ovf[1], 1);

        send(8'h41, 1'b1);
        n = 0;
        while (ti[1] != tx_list1.size() && n < 100) begin
            tick();
            n++;
        end
        check("t6_tx_seen", ti[1], tx_list1.size());
        hold = 1'b1;
        send(8'h72, 1'b1);
        send(8'h30, 1'b1);
        repeat (3) tick();
        hold = 1'b0;
        do_reset(1);
        drain("t6");

        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                idx = $urandom_range(0, 9);
                b = pool[idx];
                if (idx == 9) b = 8'($urandom_range(0, 255));
                send(b, 1'b1);
                repeat ($urandom_range(0, 3)) tick();
            end
            drain("rand");
        end
        check("rand_ovf1", ovf[1], 0);
        check("rand_ovf0", ovf[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
